trace_cmd_dispatcher: RTL and testbench

Upstream front-end of the LLC model. It accepts trace commands (opcode + address) over a valid/ready handshake and buffers them in a small FIFO. It issues exactly one request at a time to the cache on its `read_req`/`write_req`/`invalidate` inputs, then waits for the cache's completion before issuing the next. It also expands a whole-cache clear command into a per-set sweep and pulses print requests.

---
 rtl/trace_cmd_dispatcher.sv | 219 +++++++++++++++++++++
 tb/tb_trace_cmd_dispatcher.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_cmd_dispatcher.sv
// trace_cmd_dispatcher
// Front-end of the LLC model. Trace commands (opcode + address) are buffered
// in a small FIFO and issued to the cache one at a time; the next request is
// only issued after the cache reports completion. A clear command (op 8) is
// expanded into one clear_req per set. A print command (op 9) and undefined
// opcodes produce single pulses and do not wait for the cache.
//
// Optional feature: define TRACE_STATS_EN to add saturating 32-bit
// statistics counters (stat_reads, stat_writes, stat_snoops).
//
// Handshake: a command is transferred on a rising edge where
// cmd_valid && cmd_ready. cmd_ready depends only on FIFO state and rst, never
// on cmd_valid. A full FIFO deasserts cmd_ready even in a cycle that pops.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   cmd_valid/ready   upstream command handshake; cmd_op, cmd_addr payload
//   read_req, write_req, invalidate   one-cycle request pulses to the cache
//   snoop, ifetch     qualifiers, valid together with the request pulse
//   req_addr          address of the latest memory request (held)
//   clear_req         one-cycle pulse, clear set clear_index
//   print_req, bad_op one-cycle pulses for op 9 / undefined opcodes
//   cache_done        cache finished the outstanding request
//   busy              FSM active or commands buffered (registered)
//   state_dbg         current FSM state encoding
//   stat_*            statistics counters (TRACE_STATS_EN only)
module trace_cmd_dispatcher #(
  parameter int ADDR_SIZE  = 32,
  parameter int INDEX_SIZE = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [ADDR_SIZE-1:0]  cmd_addr,
  output logic                  read_req,
  output logic                  write_req,
  output logic                  invalidate,
  output logic                  snoop,
  output logic                  ifetch,
  output logic [ADDR_SIZE-1:0]  req_addr,
  output logic                  clear_req,
  output logic [INDEX_SIZE-1:0] clear_index,
  output logic                  print_req,
  input  logic                  cache_done,
  output logic                  bad_op,
  output logic                  busy,
  output logic [2:0]            state_dbg
`ifdef TRACE_STATS_EN
  ,
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_writes,
  output logic [31:0]           stat_snoops
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]      PTR_ONE  = 1;
  localparam logic [INDEX_SIZE-1:0] IDX_ONE = 1;
  localparam logic [INDEX_SIZE-1:0] IDX_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT      = 3'd2,
    S_CLR_ISSUE = 3'd3,
    S_CLR_WAIT  = 3'd4
  } state_t;

  state_t state;

  // Command FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [3:0]           op_mem   [FIFO_DEPTH];
  logic [ADDR_SIZE-1:0] addr_mem [FIFO_DEPTH];
  logic [PTR_W:0]       wr_ptr, rd_ptr;
  logic                 empty, full, push, pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign cmd_ready = rst && !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_IDLE) && !empty;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr[PTR_W-1:0]]   <= cmd_op;
      addr_mem[wr_ptr[PTR_W-1:0]] <= cmd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Command register and opcode decode.
  logic [3:0]           cur_op;
  logic [ADDR_SIZE-1:0] cur_addr;
  logic dec_mem, dec_rd, dec_wr, dec_inv, dec_snoop, dec_ifetch;

  always_comb begin
    dec_mem    = (cur_op <= 4'd6);
    dec_rd     = (cur_op == 4'd0) || (cur_op == 4'd2) || (cur_op == 4'd3) || (cur_op == 4'd5);
    dec_wr     = (cur_op == 4'd1) || (cur_op == 4'd4);
    dec_inv    = (cur_op == 4'd5) || (cur_op == 4'd6);
    dec_snoop  = (cur_op >= 4'd3) && (cur_op <= 4'd6);
    dec_ifetch = (cur_op == 4'd2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cur_op      <= '0;
      cur_addr    <= '0;
      read_req    <= 1'b0;
      write_req   <= 1'b0;
      invalidate  <= 1'b0;
      snoop       <= 1'b0;
      ifetch      <= 1'b0;
      req_addr    <= '0;
      clear_req   <= 1'b0;
      clear_index <= '0;
      print_req   <= 1'b0;
      bad_op      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Pulses and qualifiers default low; a state sets them for one cycle.
      read_req   <= 1'b0;
      write_req  <= 1'b0;
      invalidate <= 1'b0;
      snoop      <= 1'b0;
      ifetch     <= 1'b0;
      clear_req  <= 1'b0;
      print_req  <= 1'b0;
      bad_op     <= 1'b0;
      busy       <= (state != S_IDLE) || !empty;

      case (state)
        S_IDLE: begin
          if (!empty) begin
            cur_op   <= op_mem[rd_ptr[PTR_W-1:0]];
            cur_addr <= addr_mem[rd_ptr[PTR_W-1:0]];
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (dec_mem) begin
            read_req   <= dec_rd;
            write_req  <= dec_wr;
            invalidate <= dec_inv;
            snoop      <= dec_snoop;
            ifetch     <= dec_ifetch;
            req_addr   <= cur_addr;
            state      <= S_WAIT;
          end else if (cur_op == 4'd8) begin
            clear_index <= '0;
            state       <= S_CLR_ISSUE;
          end else if (cur_op == 4'd9) begin
            print_req <= 1'b1;
            state     <= S_IDLE;
          end else begin
            bad_op <= 1'b1;
            state  <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cache_done) state <= S_IDLE;
        end
        S_CLR_ISSUE: begin
          clear_req <= 1'b1;
          state     <= S_CLR_WAIT;
        end
        S_CLR_WAIT: begin
          if (cache_done) begin
            if (clear_index == IDX_MAX) begin
              clear_index <= '0;
              state       <= S_IDLE;
            end else begin
              clear_index <= clear_index + IDX_ONE;
              state       <= S_CLR_ISSUE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TRACE_STATS_EN
  // Saturating counters, updated when a command leaves ISSUE.
  logic is_issue;
  assign is_issue = (state == S_ISSUE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_snoops <= '0;
    end else if (is_issue) begin
      if (((cur_op == 4'd0) || (cur_op == 4'd2) || (cur_op == 4'd5)) && (stat_reads != '1))
        stat_reads <= stat_reads + 32'd1;
      if ((cur_op == 4'd1) && (stat_writes != '1))
        stat_writes <= stat_writes + 32'd1;
      if (dec_snoop && (stat_snoops != '1))
        stat_snoops <= stat_snoops + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trace_cmd_dispatcher.sv
// Testbench for trace_cmd_dispatcher (INDEX_SIZE=3 so a clear sweep is short).
// Every request/clear/print/bad_op pulse is compared against an expected
// event queue filled when the command is driven.
module tb_trace_cmd_dispatcher;
  localparam int AW = 32;
  localparam int IW = 3;
  localparam int EW = 8 + AW + IW;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready;
  logic [3:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic          read_req, write_req, invalidate, snoop, ifetch;
  logic [AW-1:0] req_addr;
  logic          clear_req;
  logic [IW-1:0] clear_index;
  logic          print_req, cache_done, bad_op, busy;
  logic [2:0]    state_dbg;
`ifdef TRACE_STATS_EN
  logic [31:0]   stat_reads, stat_writes, stat_snoops;
`endif

  trace_cmd_dispatcher #(.ADDR_SIZE(AW), .INDEX_SIZE(IW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .read_req(read_req), .write_req(write_req), .invalidate(invalidate),
    .snoop(snoop), .ifetch(ifetch), .req_addr(req_addr),
    .clear_req(clear_req), .clear_index(clear_index), .print_req(print_req),
    .cache_done(cache_done), .bad_op(bad_op), .busy(busy), .state_dbg(state_dbg)
`ifdef TRACE_STATS_EN
    , .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_snoops(stat_snoops)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [AW-1:0] last_addr = '0;
  int            n_rd = 0, n_wr = 0, n_sn = 0;
  bit            auto_done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] ev(input logic [7:0] p, input logic [AW-1:0] a,
                                       input logic [IW-1:0] i);
    return {p, a, i};
  endfunction

  // Pulse bit order: {read, write, inv, snoop, ifetch, clear, print, bad}
  task automatic expect_cmd(input logic [3:0] op, input logic [AW-1:0] addr);
    logic [7:0] p;
    p = 8'b0000_0001;
    case (op)
      4'd0: p = 8'b1000_0000;
      4'd1: p = 8'b0100_0000;
      4'd2: p = 8'b1000_1000;
      4'd3: p = 8'b1001_0000;
      4'd4: p = 8'b0101_0000;
      4'd5: p = 8'b1011_0000;
      4'd6: p = 8'b0011_0000;
      4'd9: p = 8'b0000_0010;
      default: p = 8'b0000_0001;
    endcase
    if (op <= 4'd6) last_addr = addr;
    if (op == 4'd0 || op == 4'd2 || op == 4'd5) n_rd++;
    if (op == 4'd1) n_wr++;
    if (op >= 4'd3 && op <= 4'd6) n_sn++;
    if (op == 4'd8) begin
      for (int i = 0; i < (1 << IW); i++) exp_q.push_back(ev(8'b0000_0100, last_addr, 3'(i)));
    end else begin
      exp_q.push_back(ev(p, last_addr, '0));
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send(input logic [3:0] op, input logic [AW-1:0] addr);
    int n;
    expect_cmd(op, addr);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", 64'(n >= 200), 64'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_done();
    cache_done = 1'b1;
    @(negedge clk);
    cache_done = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || state_dbg != 3'd0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n >= 3000), 64'd0);
  endtask

  // ---------------- cache model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (auto_done) cache_done = read_req | write_req | invalidate | clear_req;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] obs;
    forever begin
      @(negedge clk);
      obs = {read_req, write_req, invalidate, snoop, ifetch, clear_req, print_req, bad_op,
             req_addr, clear_index};
      if (obs[EW-1 -: 8] != 8'd0) begin
        if (exp_q.size() == 0) chk("unexpected_pulse", 64'(obs), 64'd0);
        else chk("event", 64'(obs), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cache_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", 64'(req_addr), 64'd0);
    chk("rst_idx", 64'(clear_index), 64'd0);
    chk("rst_pulses", 64'({read_req, write_req, invalidate, snoop, ifetch, clear_req,
                            print_req, bad_op}), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);

    // Latency: accept at edge 0, pulse during cycle 2->3.
    auto_done = 1'b1;
    send(4'd0, 32'h1234_5680);          // now in cycle 0->1
    chk("lat_c0_rd", 64'(read_req), 64'd0);
    @(negedge clk);                      // 1->2
    chk("lat_c1_rd", 64'(read_req), 64'd0);
    chk("lat_c1_busy", 64'(busy), 64'd1);
    @(negedge clk);                      // 2->3
    chk("lat_c2_rd", 64'(read_req), 64'd1);
    chk("lat_c2_addr", 64'(req_addr), 64'h1234_5680);
    repeat (3) @(negedge clk);           // 5->6
    chk("lat_busy_c5", 64'(busy), 64'd0);

    // FIFO fill with cache_done held low.
    auto_done = 1'b0;
    send(4'd1, 32'hA000_0040);
    send(4'd3, 32'hA000_0080);
    send(4'd4, 32'hA000_00C0);
    send(4'd2, 32'hA000_0100);
    send(4'd6, 32'hA000_0140);
    chk("full_ready", 64'(cmd_ready), 64'd0);
    repeat (3) @(negedge clk);
    chk("full_hold", 64'(cmd_ready), 64'd0);
    do_done();
    chk("full_before_pop", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("one_slot_open", 64'(cmd_ready), 64'd1);
    send(4'd0, 32'hA000_0180);
    chk("full_again", 64'(cmd_ready), 64'd0);
    do_done();
    auto_done = 1'b1;
    drain("fill_drain");

    // Op 5 and op 2 qualifier combinations.
    send(4'd5, 32'hFFFF_FFC0);
    send(4'd2, 32'h0000_1000);
    drain("qual_drain");

    // Clear sweep over 8 sets.
    send(4'd8, 32'hDEAD_BEEF);
    drain("clear_drain");
    chk("clear_idx_wrap", 64'(clear_index), 64'd0);

    // Print and bad opcode do not wait for the cache.
    auto_done = 1'b0;
    send(4'd9, 32'h5555_0000);
    send(4'd7, 32'h6666_0000);
    drain("print_bad_drain");
    chk("print_bad_addr", 64'(req_addr), 64'(last_addr));

`ifdef TRACE_STATS_EN
    chk("stat_reads", 64'(stat_reads), 64'(n_rd));
    chk("stat_writes", 64'(stat_writes), 64'(n_wr));
    chk("stat_snoops", 64'(stat_snoops), 64'(n_sn));
`endif

    // Reset during WAIT with two commands queued.
    send(4'd0, 32'h0000_2000);
    send(4'd1, 32'h0000_3000);
    send(4'd3, 32'h0000_4000);
    n = 0;
    while (exp_q.size() > 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_first_pulse", 64'(n >= 50), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    last_addr = '0;
    n_rd = 0; n_wr = 0; n_sn = 0;
    @(negedge clk);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd0);
    chk("mid_rst_state", 64'(state_dbg), 64'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);
    chk("post_rst_addr", 64'(req_addr), 64'd0);
`ifdef TRACE_STATS_EN
    chk("post_rst_stat_reads", 64'(stat_reads), 64'd0);
`endif

    // Random traffic after reset.
    auto_done = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(4'($urandom_range(0, 15)), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain("rand_drain");
`ifdef TRACE_STATS_EN
    chk("final_stat_reads", 64'(stat_reads), 64'(n_rd));
    chk("final_stat_writes", 64'(stat_writes), 64'(n_wr));
    chk("final_stat_snoops", 64'(stat_snoops), 64'(n_sn));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
